div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle signed 32-bit divider for the multicycle MIPS datapath; executes DIV.
- Started by the control unit's DivOp pulse; takes operands from the A and B registers.
- Returns quotient on lo_out and remainder on hi_out for the LO and HI registers.
- Signals completion or divide-by-zero back to the control unit.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- div_start  input  1  start request (DivOp), sampled on rising edge.
- dividend  input  WIDTH  numerator, from A register, two's complement.
- divisor  input  WIDTH  denominator, from B register, two's complement.
- hi_out  output  WIDTH  remainder, registered.
- lo_out  output  WIDTH  quotient, registered.
- div_busy  output  1  high while a division is in progress.
- div_done  output  1  one-cycle pulse: hi_out/lo_out valid and new.
- div_zero  output  1  one-cycle pulse: divisor was zero; control unit raises the exception.

Behaviour:
- Reset (reset_in=0, asynchronous):
  - All outputs 0; state IDLE; counter 0; internal registers 0.
  - Applies immediately, including mid-division; the aborted result is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - div_start=1 and divisor!=0 at edge k:
    - Latch |dividend| and |divisor| as unsigned WIDTH-bit values.
    - Latch q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
    - Clear the partial remainder; counter=0; div_busy=1; go to CALC.
  - div_start=1 and divisor==0 at edge k:
    - div_zero=1 for exactly the cycle after edge k.
    - hi_out/lo_out unchanged; no div_done; stay IDLE.
  - div_start=0: stay IDLE; div_done and div_zero return to 0.
- CALC:
  - One restoring step per cycle: shift {rem,quot} left 1, rem -= divisor if no borrow, set quotient LSB accordingly.
  - Counter increments each step; after step WIDTH (counter==WIDTH-1) go to FIX.
- FIX (one cycle):
  - lo_out = q_neg ? -quot : quot.
  - hi_out = r_neg ? -rem : rem (truncating division; remainder takes the dividend's sign).
  - div_done=1 next cycle; div_busy=0; go to IDLE.
- Latency: div_done is high in the cycle following edge k+WIDTH+1, i.e. 34 cycles after the start edge for WIDTH=32. div_busy is high for cycles k+1 through k+WIDTH+1.
- div_start while div_busy=1: ignored; operands are not resampled.
- div_start in the same cycle div_done is high: accepted normally, since state is IDLE.
- Overflow, 0x80000000 / 0xFFFFFFFF: magnitudes are unsigned, so quot=0x80000000 with q_neg=0. Result is lo_out=0x80000000, hi_out=0, with no exception.
- hi_out/lo_out hold their values until the next successful completion or reset.
- Arithmetic: all subtraction is WIDTH+1 bits so the borrow is observable; negation is two's complement mod 2^WIDTH.

Decomposition:
- Shared package cpu_pkg holds:
  - DIV_IDLE/DIV_CALC/DIV_FIX state encodings.
  - The WIDTH default.
  - Signal-polarity constants READ/WRITE, shared with the control unit.
- One combinational sub-module, div_step: inputs rem, quot, divisor; outputs next rem and next quot. It is reused by a future DIVM implementation.

Test Plan:
- Reset 0, then dividend=7, divisor=2, start pulse -> div_busy 1 for 33 cycles; div_done pulse 34 cycles after start; lo_out=3, hi_out=1.
- dividend=-7 (0xFFFFFFF9), divisor=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Then 7 / -2 -> lo_out=0xFFFFFFFD, hi_out=1.
- dividend=5, divisor=0 after a prior 7/2 -> div_zero pulse one cycle after start; no div_done; div_busy stays 0; hi_out=1, lo_out=3 unchanged.
- dividend=0x80000000, divisor=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_done pulse, div_zero=0.
- Start 100/7, assert reset_in=0 at cycle 10 -> all outputs 0 immediately. Release reset, start 100/7 -> lo_out=14, hi_out=2 at 34 cycles.
- Start 9/4, pulse div_start with 50/5 at cycle 5 -> second request ignored; lo_out=2, hi_out=1. Then start 50/5 on the div_done cycle -> accepted; lo_out=10, hi_out=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider state encodings, default datapath width and
// control-signal polarity constants used by the control unit.
package cpu_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_e;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quot} left,
// subtract the divisor when it fits and shift the outcome into the quotient.
module div_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quot_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;
   logic           fits;

   // Subtraction is WIDTH+1 bits wide so the borrow lands in the top bit.
   assign rem_sh = {rem_i, quot_i[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, divisor_i};
   assign fits   = ~diff[WIDTH];
   assign rem_o  = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quot_o = {quot_i[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider for DIV: quotient on lo_out, remainder on hi_out,
// truncating semantics, one restoring step per cycle plus a sign-fix cycle.
module div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             div_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_busy,
   output logic             div_done,
   output logic             div_zero
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic             start_ok, zero_req, step_en, fix_en;
   logic [WIDTH-1:0] rem_q, quot_q, dvs_q, hi_q, lo_q;
   logic [WIDTH-1:0] rem_nx, quot_nx;
   logic [CNT_W-1:0] cnt_q;
   logic             q_neg_q, r_neg_q, done_q, zero_q;

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) state_q <= DIV_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_IDLE: if (start_ok)      state_d = DIV_CALC;
         DIV_CALC: if (cnt_q == LAST) state_d = DIV_FIX;
         DIV_FIX:                     state_d = DIV_IDLE;
         default:                     state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      start_ok = (state_q == DIV_IDLE) && div_start && (divisor != '0);
      zero_req = (state_q == DIV_IDLE) && div_start && (divisor == '0);
      step_en  = (state_q == DIV_CALC);
      fix_en   = (state_q == DIV_FIX);
      div_busy = (state_q != DIV_IDLE);
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .divisor_i (dvs_q),
      .rem_o     (rem_nx),
      .quot_o    (quot_nx)
   );

   // Magnitudes are unsigned, so |0x80000000| stays representable.
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         rem_q   <= '0;
         quot_q  <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         done_q <= fix_en;
         zero_q <= zero_req;
         if (start_ok) begin
            rem_q   <= '0;
            quot_q  <= dividend[WIDTH-1] ? -dividend : dividend;
            dvs_q   <= divisor[WIDTH-1]  ? -divisor  : divisor;
            q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_q <= dividend[WIDTH-1];
            cnt_q   <= '0;
         end else if (step_en) begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q + CNT_W'(1);
         end
         if (fix_en) begin
            lo_q <= q_neg_q ? -quot_q : quot_q;
            hi_q <= r_neg_q ? -rem_q  : rem_q;
         end
      end
   end

   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign div_done = done_q;
   assign div_zero = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a timing/arithmetic reference model checked every
// cycle, plus literal expectations for each directed division.
module tb_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_in = 1'b0;
   logic         div_start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] hi_out, lo_out;
   logic         div_busy, div_done, div_zero;

   int checks = 0;
   int failures = 0;

   div_unit dut (
      .clk       (clk),
      .reset_in  (reset_in),
      .div_start (div_start),
      .dividend  (dividend),
      .divisor   (divisor),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .div_busy  (div_busy),
      .div_done  (div_done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: result is ready WIDTH+1 edges after an accepted start.
   int           m_timer = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic         m_done = 1'b0, m_zero = 1'b0;
   bit           chk_en = 1'b0;

   always @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         m_timer = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_zero = 1'b0;
      end else begin
         m_done = 1'b0;
         m_zero = 1'b0;
         if (m_timer > 0) begin
            m_timer--;
            if (m_timer == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end
         end else if (div_start) begin
            if (divisor == '0) m_zero = 1'b1;
            else begin
               longint sa, sb;
               sa = longint'($signed(dividend));
               sb = longint'($signed(divisor));
               p_lo = W'(sa / sb);
               p_hi = W'(sa % sb);
               m_timer = W + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_busy", {31'd0, div_busy}, {31'd0, m_timer > 0});
         chk("m_done", {31'd0, div_done}, {31'd0, m_done});
         chk("m_zero", {31'd0, div_zero}, {31'd0, m_zero});
         chk("m_hi", hi_out, m_hi);
         chk("m_lo", lo_out, m_lo);
      end
   end

   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      dividend = a; divisor = b; div_start = 1'b1;
      @(posedge clk); #1;
      div_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int lat, output int nbusy);
      bit got = 1'b0;
      lat = 0; nbusy = 0;
      for (int i = 1; i <= budget && !got; i++) begin
         @(negedge clk);
         if (div_busy) nbusy++;
         if (div_done) begin got = 1'b1; lat = i; end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL done_timeout: no div_done within %0d cycles", budget);
      end
   endtask

   initial begin
      int lat, nb, zcnt, dcnt, bcnt;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_hi", hi_out, 32'h0);
      chk("rst_lo", lo_out, 32'h0);
      chk("rst_busy", {31'd0, div_busy}, 32'h0);
      @(posedge clk); #1 reset_in = 1'b1;

      do_div(32'd7, 32'd2);
      wait_done(40, lat, nb);
      chk("p7_2_lat", lat, 34);
      chk("p7_2_busy", nb, 33);
      chk("p7_2_lo", lo_out, 32'd3);
      chk("p7_2_hi", hi_out, 32'd1);

      do_div(32'hFFFF_FFF9, 32'd2);
      wait_done(40, lat, nb);
      chk("n7_2_lo", lo_out, 32'hFFFF_FFFD);
      chk("n7_2_hi", hi_out, 32'hFFFF_FFFF);

      do_div(32'd7, 32'hFFFF_FFFE);
      wait_done(40, lat, nb);
      chk("p7_n2_lo", lo_out, 32'hFFFF_FFFD);
      chk("p7_n2_hi", hi_out, 32'd1);

      do_div(32'd7, 32'd2);
      wait_done(40, lat, nb);
      do_div(32'd5, 32'd0);
      zcnt = 0; dcnt = 0; bcnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) chk("z_first", {31'd0, div_zero}, 32'd1);
         if (div_zero) zcnt++;
         if (div_done) dcnt++;
         if (div_busy) bcnt++;
      end
      chk("z_pulses", zcnt, 1);
      chk("z_nodone", dcnt, 0);
      chk("z_nobusy", bcnt, 0);
      chk("z_hi", hi_out, 32'd1);
      chk("z_lo", lo_out, 32'd3);

      do_div(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(40, lat, nb);
      chk("ovf_lo", lo_out, 32'h8000_0000);
      chk("ovf_hi", hi_out, 32'h0);
      chk("ovf_zero", {31'd0, div_zero}, 32'h0);

      do_div(32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1 reset_in = 1'b0;
      #1;
      chk("mid_rst_hi", hi_out, 32'h0);
      chk("mid_rst_lo", lo_out, 32'h0);
      chk("mid_rst_busy", {31'd0, div_busy}, 32'h0);
      chk("mid_rst_done", {31'd0, div_done}, 32'h0);
      @(posedge clk); #1 reset_in = 1'b1;
      do_div(32'd100, 32'd7);
      wait_done(40, lat, nb);
      chk("r100_7_lat", lat, 34);
      chk("r100_7_lo", lo_out, 32'd14);
      chk("r100_7_hi", hi_out, 32'd2);

      do_div(32'd9, 32'd4);
      repeat (4) @(posedge clk);
      #1 dividend = 32'd50; divisor = 32'd5; div_start = 1'b1;
      @(posedge clk); #1 div_start = 1'b0;
      wait_done(40, lat, nb);
      chk("ign_lo", lo_out, 32'd2);
      chk("ign_hi", hi_out, 32'd1);
      dividend = 32'd50; divisor = 32'd5; div_start = 1'b1;
      @(posedge clk); #1 div_start = 1'b0;
      wait_done(40, lat, nb);
      chk("b2b_lat", lat, 34);
      chk("b2b_lo", lo_out, 32'd10);
      chk("b2b_hi", hi_out, 32'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
